// File: rtl/frame_pkg.sv
// Shared definitions for the frame_source capture framer.
//   cap_state_t     : capture FSM states.
//   FrameLenDefault : default samples per frame.
//   fill_width()    : width of a counter that must hold 0..depth inclusive.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE
  } cap_state_t;

  localparam int unsigned FrameLenDefault = 1024;

  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/frame_source_if.sv
// Framed output sample stream (valid/ready).
//   tdata_m  : sample
//   tuser_m  : first sample of frame
//   tlast_m  : last sample of frame
//   tvalid_m : sample valid
//   tready_m : sink ready
interface frame_source_if #(
  parameter int unsigned DW = 16
) ();

  logic [DW-1:0] tdata_m;
  logic          tuser_m;
  logic          tlast_m;
  logic          tvalid_m;
  logic          tready_m;

  modport master (
    output tdata_m,
    output tuser_m,
    output tlast_m,
    output tvalid_m,
    input  tready_m
  );

  modport slave (
    input  tdata_m,
    input  tuser_m,
    input  tlast_m,
    input  tvalid_m,
    output tready_m
  );

endinterface

// File: rtl/frame_fifo.sv
// First-word-fall-through FIFO, DW x DEPTH, built from an inferred RAM with a
// registered read followed by one output register.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : write wr_data (caller guarantees space)
//   rd_en      : sink ready; a word leaves when rd_en && !empty
//   rd_data    : head of queue, valid while !empty
//   fill       : words held, including those in the read pipeline
//   empty/full : no word presented / fill == DEPTH
module frame_fifo import frame_pkg::*; #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 2048,
  localparam int unsigned FillW = fill_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  output logic [DW-1:0]    rd_data,
  output logic [FillW-1:0] fill,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [FillW-1:0] ram_cnt_q, fill_q;
  logic [DW-1:0]    rdata_q, dout_q;
  logic             rvalid_q, ovalid_q;
  logic             pop, s1_move, rd_issue;

  // Pipeline: RAM -> rdata_q (stage 1) -> dout_q (presented word).
  always_comb begin
    pop      = ovalid_q & rd_en;
    s1_move  = rvalid_q & (~ovalid_q | pop);
    // Only words written on an earlier edge are read, so no read-during-write hazard.
    rd_issue = (ram_cnt_q != '0) & (~rvalid_q | s1_move);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= wr_data;
    end
    if (rd_issue) begin
      rdata_q <= mem[rptr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      fill_q    <= '0;
      rvalid_q  <= 1'b0;
      ovalid_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      if (wr_en) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (rd_issue) begin
        rptr_q <= rptr_q + AW'(1);
      end
      ram_cnt_q <= ram_cnt_q + FillW'(wr_en) - FillW'(rd_issue);
      fill_q    <= fill_q + FillW'(wr_en) - FillW'(pop);
      if (rd_issue) begin
        rvalid_q <= 1'b1;
      end else if (s1_move) begin
        rvalid_q <= 1'b0;
      end
      if (s1_move) begin
        dout_q   <= rdata_q;
        ovalid_q <= 1'b1;
      end else if (pop) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  assign rd_data = dout_q;
  assign fill    = fill_q;
  assign empty   = ~ovalid_q;
  assign full    = (fill_q == FillW'(DEPTH));

endmodule

// File: rtl/frame_source.sv
// Capture-side framer: turns the free-running ADC sample stream into whole
// frames of FRAME_LEN samples with tuser on the first and tlast on the last.
// A frame is started only when the FIFO can hold all of it.
//   clk, reset   : clock, asynchronous active-high reset
//   ce           : capture enable, gates sample acceptance
//   sample_data  : ADC sample, qualified by sample_valid (no backpressure)
//   arm          : single-shot frame request (1-cycle pulse), also clears skipped
//   cont         : continuous mode, frames back to back
//   m_axis       : framed output stream (master)
//   skipped      : sticky, a frame start was refused for lack of space
//   capturing    : capture FSM is in CAPTURE
module frame_source import frame_pkg::*; #(
  parameter int unsigned DW        = 16,
  parameter int unsigned FRAME_LEN = FrameLenDefault,
  parameter int unsigned DEPTH     = 2 * FRAME_LEN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic [DW-1:0] sample_data,
  input  logic          sample_valid,
  input  logic          arm,
  input  logic          cont,
  frame_source_if.master m_axis,
  output logic          skipped,
  output logic          capturing
);

  localparam int unsigned FillW = fill_width(DEPTH);
  localparam int unsigned CntW  = $clog2(FRAME_LEN);

  cap_state_t       state_q, state_d;
  logic [CntW-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q;
  logic             skipped_q, skipped_d;
  logic             samp, wr_en, pop;
  logic             fifo_empty, fifo_full;
  logic [DW-1:0]    fifo_data;
  logic [FillW-1:0] fill, free;
  logic             room_now, room_next;

  assign samp      = sample_valid & ce;
  assign free      = FillW'(DEPTH) - fill;
  // Registered fill only: a read on this cycle is not credited.
  assign room_now  = (free >= FillW'(FRAME_LEN));
  // Room for a whole frame after the write that ends the current one.
  assign room_next = (free > FillW'(FRAME_LEN));

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    skipped_d = skipped_q;
    wr_en     = 1'b0;
    if (arm) begin
      skipped_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (arm | cont) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (samp) begin
          if (room_now) begin
            wr_en    = 1'b1;
            wr_cnt_d = CntW'(1);
            state_d  = CAPTURE;
          end else begin
            skipped_d = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (samp) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CntW'(1);  // wraps to 0 after the last sample
          if (wr_cnt_q == CntW'(FRAME_LEN - 1)) begin
            if (!cont) begin
              state_d = IDLE;
            end else if (room_next) begin
              state_d = CAPTURE;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      skipped_q <= 1'b0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      skipped_q <= skipped_d;
      if (pop) begin
        rd_cnt_q <= rd_cnt_q + CntW'(1);
      end
    end
  end

  frame_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en & ~fifo_full),
    .wr_data (sample_data),
    .rd_en   (m_axis.tready_m),
    .rd_data (fifo_data),
    .fill    (fill),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign pop             = ~fifo_empty & m_axis.tready_m;
  assign m_axis.tvalid_m = ~fifo_empty;
  assign m_axis.tdata_m  = fifo_data;
  assign m_axis.tuser_m  = ~fifo_empty & (rd_cnt_q == '0);
  assign m_axis.tlast_m  = ~fifo_empty & (rd_cnt_q == CntW'(FRAME_LEN - 1));

  assign skipped   = skipped_q;
  assign capturing = (state_q == CAPTURE);

endmodule

// File: tb/tb_frame_source.sv
module tb_frame_source;

  localparam int DW    = 16;
  localparam int FL    = 16;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b0;
  logic          sample_valid = 1'b0;
  logic          arm = 1'b0;
  logic          cont = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          skipped, capturing;

  frame_source_if #(.DW(DW)) axis ();

  frame_source #(
    .DW        (DW),
    .FRAME_LEN (FL),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .arm          (arm),
    .cont         (cont),
    .m_axis       (axis),
    .skipped      (skipped),
    .capturing    (capturing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            user;
    bit            last;
    longint        wt;
  } beat_t;

  // Reference model: queue of accepted samples tagged with frame position and
  // write edge; a sample is presentable 2 edges after its write.
  beat_t  mq[$];
  beat_t  out_log[$];
  int     m_fill = 0;
  bit     m_req = 1'b0;
  int     m_pos = -1;  // samples written in current frame, -1 when not capturing
  bit     m_skip = 1'b0;
  longint cyc = 0;
  longint first_wr = -1;
  longint first_vld = -1;
  int     ramp = 0;
  bit     ce0_seen [int];
  int     n_checks = 0;
  int     n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit exp_valid(input longint c);
    return (mq.size() > 0) && (mq[0].wt + 2 <= c);
  endfunction

  task automatic model_step();
    bit samp, pop, wr;
    int fill_r, tag;
    if (reset) begin
      mq.delete();
      m_fill = 0;
      m_req  = 1'b0;
      m_pos  = -1;
      m_skip = 1'b0;
      cyc++;
      return;
    end
    samp   = sample_valid && ce;
    pop    = exp_valid(cyc) && axis.tready_m;
    cyc++;
    fill_r = m_fill;
    wr     = 1'b0;
    tag    = 0;
    if (arm) m_skip = 1'b0;
    if (m_pos >= 0) begin
      if (samp) begin
        wr  = 1'b1;
        tag = m_pos;
        m_pos++;
        if (m_pos == FL) begin
          if (!cont) m_pos = -1;
          else if (DEPTH - (fill_r + 1) >= FL) m_pos = 0;
          else begin
            m_pos = -1;
            m_req = 1'b1;
          end
        end
      end
    end else if (m_req) begin
      if (samp) begin
        if (DEPTH - fill_r >= FL) begin
          wr    = 1'b1;
          tag   = 0;
          m_pos = 1;
          m_req = 1'b0;
        end else begin
          m_skip = 1'b1;
        end
      end
    end else if (arm || cont) begin
      m_req = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (wr) begin
      mq.push_back('{data: sample_data, user: (tag == 0), last: (tag == FL - 1), wt: cyc});
      if (first_wr < 0) first_wr = cyc;
    end
    m_fill = fill_r + int'(wr) - int'(pop);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare against the model, plus a log of accepted output beats.
  initial forever begin
    bit ev;
    @(negedge clk);
    if (reset) begin
      check("reset_outputs", {axis.tvalid_m, axis.tuser_m, axis.tlast_m, axis.tdata_m,
                              skipped, capturing}, '0);
    end else begin
      ev = exp_valid(cyc);
      check("tvalid", axis.tvalid_m, ev);
      if (ev) begin
        check("beat", {axis.tdata_m, axis.tuser_m, axis.tlast_m},
              {mq[0].data, mq[0].user, mq[0].last});
      end
      check("status", {skipped, capturing}, {m_skip, m_pos >= 0});
      if (axis.tvalid_m && first_vld < 0) first_vld = cyc;
      if (axis.tvalid_m && axis.tready_m) begin
        out_log.push_back('{data: axis.tdata_m, user: axis.tuser_m, last: axis.tlast_m,
                            wt: cyc});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input bit sv, input bit cev, input bit a);
    @(posedge clk);
    #1;
    sample_valid = sv;
    ce           = cev;
    arm          = a;
    sample_data  = ramp[DW-1:0];
    if (sv) begin
      if (!cev) ce0_seen[ramp] = 1'b1;
      ramp++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cont  = 1'b0;
    arm   = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    out_log.delete();
    first_wr  = -1;
    first_vld = -1;
  endtask

  task automatic check_frames(input string name, input int nbeats);
    logic [DW-1:0] base;
    if (out_log.size() < nbeats) begin
      check({name, "_count"}, out_log.size(), nbeats);
      return;
    end
    base = out_log[0].data;
    for (int i = 0; i < nbeats; i++) begin
      check(name, {out_log[i].data, out_log[i].user, out_log[i].last},
            {base + DW'(i), (i % FL) == 0, (i % FL) == FL - 1});
    end
  endtask

  initial begin
    int hits, users;
    bit sv, cev, rdy;
    axis.tready_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Continuous capture at full rate.
    do_reset();
    axis.tready_m = 1'b1;
    cont = 1'b1;
    repeat (70) tick(1'b1, 1'b1, 1'b0);
    check("t1_latency", first_vld - first_wr, 2);
    check_frames("t1_frame", 48);
    cont = 1'b0;
    repeat (40) tick(1'b1, 1'b1, 1'b0);
    check("t1_whole_frames", out_log.size() % FL, 0);
    check("t1_idle", capturing, 1'b0);

    // Single-shot arm.
    do_reset();
    axis.tready_m = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    repeat (60) tick(1'b1, 1'b1, 1'b0);
    check("t2_one_frame", out_log.size(), FL);
    check_frames("t2_frame", FL);
    check("t2_tvalid_low", axis.tvalid_m, 1'b0);

    // Backpressure: two frames stored, third refused.
    do_reset();
    axis.tready_m = 1'b0;
    cont = 1'b1;
    repeat (60) tick(1'b1, 1'b1, 1'b0);
    check("t3_skipped", skipped, 1'b1);
    check("t3_nothing_out", out_log.size(), 0);
    check("t3_held_valid", axis.tvalid_m, 1'b1);
    axis.tready_m = 1'b1;
    repeat (60) tick(1'b1, 1'b1, 1'b0);
    cont = 1'b0;
    repeat (40) tick(1'b1, 1'b1, 1'b0);
    check_frames("t3_stored", 2 * FL);
    if (out_log.size() > 2 * FL) begin
      check("t3_fresh_user", out_log[2 * FL].user, 1'b1);
      check("t3_fresh_gap", out_log[2 * FL].data != out_log[2 * FL - 1].data + DW'(1), 1'b1);
    end else begin
      check("t3_fresh_frame", out_log.size() > 2 * FL, 1'b1);
    end

    // Random valid/ready with ce toggling.
    do_reset();
    ce0_seen.delete();
    cont = 1'b1;
    cev  = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 99) < 8) cev = !cev;
      sv  = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 50);
      tick(sv, cev, 1'b0);
      axis.tready_m = rdy;
    end
    cont = 1'b0;
    axis.tready_m = 1'b1;
    repeat (100) tick(1'b1, 1'b1, 1'b0);
    check("t4_whole_frames", out_log.size() % FL, 0);
    hits  = 0;
    users = 0;
    foreach (out_log[i]) begin
      if (ce0_seen.exists(int'(out_log[i].data))) hits++;
      if (out_log[i].user) users++;
    end
    check("t4_ce0_absent", hits, 0);
    check("t4_frame_starts", users, out_log.size() / FL);
    check("t4_some_frames", out_log.size() >= 2 * FL, 1'b1);

    // Reset in the middle of a frame.
    do_reset();
    axis.tready_m = 1'b1;
    cont = 1'b1;
    for (int k = 0; k < 200 && !(out_log.size() >= 20 && m_pos == 7); k++) begin
      tick(1'b1, 1'b1, 1'b0);
    end
    check("t5_reached_write7", m_pos, 7);
    reset = 1'b1;
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    out_log.delete();
    repeat (60) tick(1'b1, 1'b1, 1'b0);
    check("t5_output_resumed", out_log.size() > 0, 1'b1);
    if (out_log.size() > 0) check("t5_first_tuser", out_log[0].user, 1'b1);

    // arm during CAPTURE with skipped set.
    do_reset();
    axis.tready_m = 1'b0;
    cont = 1'b1;
    repeat (60) tick(1'b1, 1'b1, 1'b0);
    cont = 1'b0;
    check("t6_skipped_set", skipped, 1'b1);
    axis.tready_m = 1'b1;
    for (int k = 0; k < 100 && !capturing; k++) tick(1'b1, 1'b1, 1'b0);
    check("t6_capturing", capturing, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    check("t6_skip_cleared", skipped, 1'b0);
    repeat (80) tick(1'b1, 1'b1, 1'b0);
    check("t6_frame_count", out_log.size(), 3 * FL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
